// File: rtl/bus_mux_pipe.sv
// N-input registered bus selector with valid/ready handshake and sticky out-of-range flag.
// Define BUSMUX_SKID_EN to add a 2-entry skid buffer and make in_ready a flop output.
module bus_mux_pipe #(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_bus,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);
    logic [WIDTH-1:0] word;
    logic             sel_oob;
    logic             accept;
    logic [WIDTH-1:0] m_data;
    logic [SEL_W-1:0] m_sel;
    logic             m_valid;

    // An out-of-range select matches no bus and therefore yields an all-zero word.
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) word = in_bus[i*WIDTH +: WIDTH];
        end
    end

    assign sel_oob = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 sel_err <= 1'b0;
        else if (accept && sel_oob) sel_err <= 1'b1;
    end

`ifdef BUSMUX_SKID_EN
    logic [WIDTH-1:0] s_data;
    logic [SEL_W-1:0] s_sel;
    logic             s_valid;
    logic             s_valid_n;
    logic             rdy_q;
    logic             m_free;

    assign m_free = !m_valid || out_ready;

    // Input is only accepted while S is empty, so a free M always absorbs S or the new word.
    always_comb begin
        s_valid_n = s_valid;
        if (flush)       s_valid_n = 1'b0;
        else if (m_free) s_valid_n = 1'b0;
        else if (accept) s_valid_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_sel   <= '0;
            rdy_q   <= 1'b1;
        end else begin
            s_valid <= s_valid_n;
            rdy_q   <= !s_valid_n;
            if (flush) begin
                m_valid <= 1'b0;
            end else if (m_free) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= s_data;
                    m_sel   <= s_sel;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_data  <= word;
                    m_sel   <= sel;
                end else begin
                    m_valid <= 1'b0;
                end
            end
            if (!flush && !m_free && accept) begin
                s_data <= word;
                s_sel  <= sel;
            end
        end
    end

    assign in_ready = rdy_q;
`else
    assign in_ready = !m_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= word;
            m_sel   <= sel;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end
`endif

    assign out_bus   = m_data;
    assign out_sel   = m_sel;
    assign out_valid = m_valid;

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Self-checking bench for bus_mux_pipe: table vectors, corner-case sequences and
// randomized traffic checked against a FIFO-capacity reference model.
module tb_bus_mux_pipe;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*W-1:0] in_bus;
    logic [1:0]     sel;
    logic           in_valid, in_ready, flush, out_valid, out_ready, sel_err;
    logic [W-1:0]   out_bus;
    logic [1:0]     out_sel;

    logic [3*W-1:0] in_bus3;
    logic [1:0]     sel3;
    logic           in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
    logic [W-1:0]   out_bus3;
    logic [1:0]     out_sel3;

    always #5 clk = ~clk;

    bus_mux_pipe #(.WIDTH(W), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_bus(out_bus), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    bus_mux_pipe #(.WIDTH(W), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .flush(flush3), .out_bus(out_bus3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
    } ent_t;

    typedef struct {
        logic [1:0]   s;
        logic         iv, ordy, fl, ev;
        logic [W-1:0] eb;
        logic [1:0]   es;
    } vec_t;

    ent_t q[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [W-1:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003, D = 32'hDDDD_0004;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Capacity of the buffer decides acceptance: two words with skid, one (or a draining one) without.
    function automatic bit model_rdy();
`ifdef BUSMUX_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || (out_ready == 1'b1);
`endif
    endfunction

    task automatic cycle(input logic [1:0] s, input logic iv, input logic ordy, input logic fl);
        bit   rdy;
        ent_t e;
        sel = s; in_valid = iv; out_ready = ordy; flush = fl;
        #3;
        rdy = model_rdy();
        chk("in_ready", in_ready, rdy);
        e.d = in_bus[s*W +: W];
        e.s = s;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back(e);
        end
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_bus", out_bus, q[0].d);
            chk("out_sel", out_sel, q[0].s);
        end
        chk("sel_err4", sel_err, 0);
    endtask

    task automatic cycle3(input logic [1:0] s, input logic iv);
        sel3 = s; in_valid3 = iv; out_ready3 = 1'b1; flush3 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_abcd();
        in_bus = {D, C, B, A};
    endtask

    initial begin
        rst_n = 1'b0; in_bus = '0; sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_bus3 = '0; sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;
        q.delete();
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bus", out_bus, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid3", out_valid3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through, hold, drain-and-load and flush vectors
        for (int i = 0; i < 4; i++) in_bus[i*W +: W] = W'(32'h1111_1111 * i);
        tbl[0] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 2'd0};
        tbl[1] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 2'd1};
        tbl[2] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 2'd2};
        tbl[3] = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3333_3333, 2'd3};
        tbl[4] = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0};
        tbl[5] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 2'd3};
        tbl[6] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 2'd3};
        tbl[7] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 2'd1};
        tbl[8] = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'd0};
        tbl[9] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 2'd2};
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].s, tbl[i].iv, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_bus", i), out_bus, tbl[i].eb);
                chk($sformatf("tbl%0d_sel", i), out_sel, tbl[i].es);
            end
        end
        cycle(2'd0, 1'b0, 1'b1, 1'b0);

        set_abcd();
`ifdef BUSMUX_SKID_EN
        // Backpressure for three cycles with A on the output
        cycle(2'd0, 1'b1, 1'b1, 1'b0); chk("bp_a", out_bus, A);
        cycle(2'd1, 1'b1, 1'b0, 1'b0); chk("bp_hold1", out_bus, A);
        chk("bp_rdy1", in_ready, 0);
        cycle(2'd2, 1'b1, 1'b0, 1'b0); chk("bp_hold2", out_bus, A);
        chk("bp_rdy2", in_ready, 0);
        cycle(2'd2, 1'b1, 1'b0, 1'b0); chk("bp_hold3", out_bus, A);
        cycle(2'd2, 1'b1, 1'b1, 1'b0); chk("bp_b", out_bus, B); chk("bp_b_v", out_valid, 1);
        cycle(2'd2, 1'b1, 1'b1, 1'b0); chk("bp_c", out_bus, C); chk("bp_c_v", out_valid, 1);
        cycle(2'd2, 1'b0, 1'b1, 1'b0); chk("bp_empty", out_valid, 0);
`else
        // Combinational in_ready follows out_ready while M is full
        cycle(2'd0, 1'b1, 1'b1, 1'b0); chk("ns_a", out_bus, A);
        sel = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
        #1 chk("ns_rdy_low", in_ready, 0);
        out_ready = 1'b1;
        #1 chk("ns_rdy_high", in_ready, 1);
        cycle(2'd1, 1'b1, 1'b1, 1'b0); chk("ns_b", out_bus, B); chk("ns_b_v", out_valid, 1);
        cycle(2'd0, 1'b0, 1'b1, 1'b0); chk("ns_empty", out_valid, 0);
`endif

        // Flush with held data and D offered
        cycle(2'd0, 1'b1, 1'b1, 1'b0);
        cycle(2'd1, 1'b1, 1'b0, 1'b0);
        cycle(2'd3, 1'b1, 1'b1, 1'b1);
        chk("fl_valid", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        cycle(2'd3, 1'b0, 1'b1, 1'b0);
        chk("fl_no_d", out_valid, 0);

        for (int i = 0; i < 400; i++) begin
            in_bus = {$urandom, $urandom, $urandom, $urandom};
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        cycle(2'd0, 1'b0, 1'b1, 1'b0);
        cycle(2'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges with M full
        set_abcd();
        cycle(2'd1, 1'b1, 1'b0, 1'b0);
        chk("ar_full", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_bus", out_bus, 0);
        chk("ar_sel", out_sel, 0);
        chk("ar_rdy", in_ready, 1);
        q.delete();
        rst_n = 1'b1;
        cycle(2'd2, 1'b1, 1'b1, 1'b0);
        chk("ar_first", out_bus, C);
        chk("ar_first_v", out_valid, 1);
        cycle(2'd0, 1'b0, 1'b1, 1'b0);

        // Out-of-range select on the 3-input instance
        in_bus3 = {C, B, A};
        cycle3(2'd1, 1'b1);
        chk("oor_b", out_bus3, B); chk("oor_b_err", sel_err3, 0);
        cycle3(2'd3, 1'b1);
        chk("oor_bus", out_bus3, 0); chk("oor_valid", out_valid3, 1);
        chk("oor_sel", out_sel3, 3); chk("oor_err", sel_err3, 1);
        cycle3(2'd0, 1'b1);
        chk("oor_a", out_bus3, A); chk("oor_sticky1", sel_err3, 1);
        cycle3(2'd2, 1'b1);
        chk("oor_c", out_bus3, C); chk("oor_sticky2", sel_err3, 1);
        cycle3(2'd2, 1'b0);
        chk("oor_idle", out_valid3, 0); chk("oor_sticky3", sel_err3, 1);
        chk("oor_rdy3", in_ready3, 1);
        #2 rst_n = 1'b0;
        #1 chk("oor_rst_err", sel_err3, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("oor_after_rst", sel_err3, 0);
        chk("dut4_idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bus_mux_pipe.md
# bus_mux_pipe

Parametrised N-input, WIDTH-bit bus selector with a registered output stage and a valid/ready handshake. It is the pipelined successor to the combinational 32-bit 2:1 bus mux. It is used in the pipelined MIPS datapath for operand-forwarding and writeback selects, where the chosen bus must be held across stalls and dropped on flush. An optional 2-entry skid buffer gives full throughput while keeping `in_ready` a registered signal.

## Interface
- `WIDTH`, 32, bit width of each input bus and of the output
- `NUM_IN`, 4, number of input buses (≥2)
- `SEL_W`, `$clog2(NUM_IN)`, select width (localparam, derived)
- `clk`  input  1  rising-edge clock; the block's only clock
- `rst_n`  input  1  asynchronous, active-low reset
- `in_bus`  input  NUM_IN*WIDTH  concatenated inputs; bus i = `in_bus[i*WIDTH +: WIDTH]`
- `sel`  input  SEL_W  binary select, sampled with `in_valid`
- `in_valid`  input  1  upstream offers `{in_bus, sel}`
- `in_ready`  output  1  block can accept this cycle
- `flush`  input  1  synchronous discard of all held and incoming data
- `out_bus`  output  WIDTH  selected bus, registered
- `out_sel`  output  SEL_W  select value that produced `out_bus`
- `out_valid`  output  1  `out_bus` and `out_sel` are valid
- `out_ready`  input  1  downstream consumes this cycle
- `sel_err`  output  1  sticky flag: a transfer was accepted with `sel` ≥ NUM_IN

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready` at a rising edge.
- On transfer in, the word bus[sel] and `sel` are captured.
- Out-of-range `sel` (≥ NUM_IN, only possible when NUM_IN is not a power of 2) captures an all-zero word and sets `sel_err`. `sel_err` stays set until reset.
- Main register (M) drives the outputs. The skid register (S) exists only with `BUSMUX_SKID_EN`.
- With skid, `in_ready = !S.valid`, driven from a flop.
  - A transfer in while M is valid and not draining is stored in S.
  - When M drains, S moves into M, or the new input moves into M if S is empty.
- Ordering is strict FIFO. No word is lost or duplicated.
- `flush` clears M.valid and S.valid at the next edge. An input offered in the same cycle is accepted, so `in_ready` still applies, but it is discarded. `sel_err` is still updated for that input.
- Data registers are not required to clear on flush. Only the valid bits are required to clear.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on `out_bus` with `out_valid=1` after edge k.
- Throughput is 1 word/cycle while `out_ready` is held at 1.
- Reset (`rst_n=0`, asynchronous) sets:
  - `out_valid=0`, `out_bus=0`, `out_sel=0`, `sel_err=0`
  - S cleared
  - `in_ready=1`, both with and without skid
- Reset asserted in the middle of a transfer drops all held words immediately. After reset releases, the first edge can accept new data.
- `out_bus` and `out_sel` are stable while `out_valid && !out_ready`.
- Simultaneous transfer in and transfer out with M full and S empty: M is loaded with the new word and S stays empty.
- `flush` takes priority over every load in the same cycle.

## Configuration
- `BUSMUX_SKID_EN` defined:
  - 2-entry (M+S) buffer
  - `in_ready` is registered and has no combinational path from `out_ready`
  - full throughput under backpressure release
- Not defined:
  - M only
  - `in_ready = !M.valid || out_ready` is combinational from `out_ready`
  - same latency and throughput while `out_ready=1`

## Test plan
- Pass-through: NUM_IN=4, inputs `32'h1111_1111 × i`, sweep sel 0..3 with `in_valid=1`, `out_ready=1` → `out_bus` = the corresponding bus one cycle later, `out_sel` matches, one output per cycle.
- Backpressure (skid): stream A,B,C; hold `out_ready=0` for 3 cycles starting when A is on the output.
  - Required: `out_bus` holds A, B goes into S, `in_ready=0` while C waits.
  - After release, A, B, C are delivered in order with no gaps.
- Flush: M and S full with `flush=1` and a new word D offered → next cycle `out_valid=0`, D never appears, `in_ready=1`.
- Out-of-range: NUM_IN=3, sel=3 accepted → `out_bus=0`, `out_valid=1`, `sel_err=1`; `sel_err` stays 1 through later valid sels until `rst_n` pulses low.
- Async reset in the middle of a stream: drop `rst_n` between edges with M full → `out_valid` goes to 0 immediately, outputs are zero, and the first accepted word after release appears one cycle later.
- Non-skid build: `out_ready=0` with M full → `in_ready=0` in the same cycle; raising `out_ready` raises `in_ready` combinationally and a new word loads as M drains.
